// File: rtl/dm_pkg.sv
`default_nettype none
// ============================================================================
// dm_pkg : shared constants and types for the debug-module run control | rev 1.0
// ============================================================================
package dm_pkg;

  localparam logic [6:0] DMI_ADDR_DATA0      = 7'h04;
  localparam logic [6:0] DMI_ADDR_DMCONTROL  = 7'h10;
  localparam logic [6:0] DMI_ADDR_DMSTATUS   = 7'h11;
  localparam logic [6:0] DMI_ADDR_ABSTRACTCS = 7'h16;
  localparam logic [6:0] DMI_ADDR_COMMAND    = 7'h17;

  typedef enum logic [1:0] {
    DMI_OP_NOP   = 2'd0,
    DMI_OP_READ  = 2'd1,
    DMI_OP_WRITE = 2'd2,
    DMI_OP_RSVD  = 2'd3
  } dmi_op_e;

  localparam logic [1:0] DMI_RSP_OK     = 2'd0;
  localparam logic [1:0] DMI_RSP_FAILED = 2'd2;

  typedef enum logic [2:0] {
    CMDERR_NONE       = 3'd0,
    CMDERR_BUSY       = 3'd1,
    CMDERR_NOTSUP     = 3'd2,
    CMDERR_EXCEPT     = 3'd3,
    CMDERR_HALTRESUME = 3'd4
  } cmderr_e;

  typedef enum logic [1:0] {
    ABS_IDLE = 2'd0,
    ABS_REQ  = 2'd1,
    ABS_WAIT = 2'd2
  } abs_state_e;

  localparam int DMCONTROL_HALTREQ   = 31;
  localparam int DMCONTROL_RESUMEREQ = 30;
  localparam int DMCONTROL_NDMRESET  = 1;
  localparam int DMCONTROL_DMACTIVE  = 0;

  localparam int DMSTATUS_ALLRESUMEACK  = 17;
  localparam int DMSTATUS_ANYRESUMEACK  = 16;
  localparam int DMSTATUS_ALLRUNNING    = 11;
  localparam int DMSTATUS_ANYRUNNING    = 10;
  localparam int DMSTATUS_ALLHALTED     = 9;
  localparam int DMSTATUS_ANYHALTED     = 8;
  localparam int DMSTATUS_AUTHENTICATED = 7;
  localparam int DMSTATUS_VERSION_LSB   = 0;
  localparam logic [3:0] DM_VERSION     = 4'd2;

  localparam int ABSTRACTCS_BUSY          = 12;
  localparam int ABSTRACTCS_CMDERR_LSB    = 8;
  localparam int ABSTRACTCS_DATACOUNT_LSB = 0;
  localparam logic [3:0] DM_DATACOUNT     = 4'd1;

  localparam int CMD_CMDTYPE_LSB = 24;
  localparam int CMD_AARSIZE_LSB = 20;
  localparam int CMD_TRANSFER    = 17;
  localparam int CMD_WRITE       = 16;
  localparam logic [2:0] AARSIZE_32 = 3'd2;

endpackage
`default_nettype wire

// File: rtl/dm_run_ctl_if.sv
`default_nettype none
// ============================================================================
// dm_run_ctl_if : DMI request/response bundle between transport and DM | rev 1.0
// ============================================================================
interface dm_run_ctl_if #(
  parameter int AddrWidth = 7,
  parameter int Xlen      = 32
);
  logic                 dmi_valid;
  logic [AddrWidth-1:0] dmi_addr;
  logic [Xlen-1:0]      dmi_data;
  logic [1:0]           dmi_op;
  logic                 dmi_rsp_valid;
  logic [Xlen-1:0]      dmi_rsp_data;
  logic [1:0]           dmi_rsp_op;

  modport master (
    output dmi_valid, dmi_addr, dmi_data, dmi_op,
    input  dmi_rsp_valid, dmi_rsp_data, dmi_rsp_op
  );

  modport slave (
    input  dmi_valid, dmi_addr, dmi_data, dmi_op,
    output dmi_rsp_valid, dmi_rsp_data, dmi_rsp_op
  );
endinterface
`default_nettype wire

// File: rtl/dm_abstract_cmd.sv
`default_nettype none
// ============================================================================
// dm_abstract_cmd : Access Register engine, timeout counter and data0 | rev 1.0
// ============================================================================
module dm_abstract_cmd
  import dm_pkg::*;
#(
  parameter int Xlen       = 32,
  parameter int CmdTimeout = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            data0_wr,
  input  logic            data0_rd,
  input  logic            abstractcs_wr,
  input  logic            command_wr,
  input  logic [Xlen-1:0] wdata,
  input  logic            hart_halted,
  output logic [Xlen-1:0] data0,
  output logic            busy,
  output cmderr_e         cmderr,
  output logic            reg_req,
  output logic            reg_write,
  output logic [15:0]     reg_addr,
  output logic [Xlen-1:0] reg_wdata,
  input  logic [Xlen-1:0] reg_rdata,
  input  logic            reg_ack,
  input  logic            reg_err
);

  localparam int             CNT_W       = $clog2(CmdTimeout + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_MAX = CNT_W'(CmdTimeout);

  abs_state_e       state_q, state_d;
  cmderr_e          cmderr_q, cmderr_d;
  logic [Xlen-1:0]  data0_q, data0_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cmd_write_q, cmd_write_d;
  logic [15:0]      regno_q, regno_d;
  logic             busy_err;

  always_comb begin
    state_d     = state_q;
    cmderr_d    = cmderr_q;
    data0_d     = data0_q;
    cnt_d       = cnt_q;
    cmd_write_d = cmd_write_q;
    regno_d     = regno_q;
    busy_err    = 1'b0;

    if (abstractcs_wr) begin
      cmderr_d = cmderr_e'(cmderr_q & ~wdata[ABSTRACTCS_CMDERR_LSB +: 3]);
    end

    if (data0_wr || data0_rd) begin
      if (busy) busy_err = 1'b1;
      else if (data0_wr) data0_d = wdata;
    end

    // A new command is only decoded from a clean, idle engine.
    if (command_wr) begin
      if (busy) begin
        busy_err = 1'b1;
      end else if (cmderr_q == CMDERR_NONE) begin
        if ((wdata[CMD_CMDTYPE_LSB +: 8] != 8'd0) || (wdata[CMD_AARSIZE_LSB +: 3] != AARSIZE_32)) begin
          cmderr_d = CMDERR_NOTSUP;
        end else if (!hart_halted) begin
          cmderr_d = CMDERR_HALTRESUME;
        end else if (wdata[CMD_TRANSFER]) begin
          state_d     = ABS_REQ;
          cmd_write_d = wdata[CMD_WRITE];
          regno_d     = wdata[15:0];
        end
      end
    end

    if (busy_err && (cmderr_q == CMDERR_NONE)) cmderr_d = CMDERR_BUSY;

    case (state_q)
      ABS_REQ, ABS_WAIT: begin
        if (reg_ack) begin
          state_d = ABS_IDLE;
          if (reg_err) cmderr_d = CMDERR_EXCEPT;
          else if (!cmd_write_q) data0_d = reg_rdata;
        end else if (state_q == ABS_REQ) begin
          state_d = ABS_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_MAX) begin
          state_d  = ABS_IDLE;
          cmderr_d = CMDERR_EXCEPT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase

    // Deactivating the DM abandons any in-flight access; a late ack then lands in IDLE.
    if (clr) begin
      state_d     = ABS_IDLE;
      cmderr_d    = CMDERR_NONE;
      data0_d     = '0;
      cnt_d       = '0;
      cmd_write_d = 1'b0;
      regno_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ABS_IDLE;
      cmderr_q    <= CMDERR_NONE;
      data0_q     <= '0;
      cnt_q       <= '0;
      cmd_write_q <= 1'b0;
      regno_q     <= '0;
    end else begin
      state_q     <= state_d;
      cmderr_q    <= cmderr_d;
      data0_q     <= data0_d;
      cnt_q       <= cnt_d;
      cmd_write_q <= cmd_write_d;
      regno_q     <= regno_d;
    end
  end

  assign busy      = (state_q != ABS_IDLE);
  assign cmderr    = cmderr_q;
  assign data0     = data0_q;
  assign reg_req   = busy;
  assign reg_write = busy & cmd_write_q;
  assign reg_addr  = busy ? regno_q : 16'h0000;
  assign reg_wdata = busy ? data0_q : '0;

endmodule
`default_nettype wire

// File: rtl/dm_run_ctl.sv
`default_nettype none
// ============================================================================
// dm_run_ctl : DMI register file, halt/resume control and abstract commands | rev 1.0
// ============================================================================
module dm_run_ctl
  import dm_pkg::*;
#(
  parameter int AddrWidth  = 7,
  parameter int Xlen       = 32,
  parameter int CmdTimeout = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  dm_run_ctl_if.slave     dmi,
  output logic            ndmreset,
  output logic            halt_req,
  output logic            resume_req,
  input  logic            hart_halted,
  input  logic            hart_resumeack,
  output logic            reg_req,
  output logic            reg_write,
  output logic [15:0]     reg_addr,
  output logic [Xlen-1:0] reg_wdata,
  input  logic [Xlen-1:0] reg_rdata,
  input  logic            reg_ack,
  input  logic            reg_err
);

  logic            dmactive_q, dmactive_d;
  logic            haltreq_q, haltreq_d;
  logic            ndmreset_q, ndmreset_d;
  logic            resume_req_q, resume_req_d;
  logic            resumeack_q, resumeack_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [Xlen-1:0] rsp_data_q, rsp_data_d;
  logic [1:0]      rsp_op_q, rsp_op_d;

  logic            is_wr, is_rd, abs_clr, busy;
  logic [Xlen-1:0] wdata, data0, dmcontrol_rd, dmstatus_rd, abstractcs_rd;
  cmderr_e         cmderr;

  assign wdata   = dmi.dmi_data;
  assign is_wr   = dmi.dmi_valid && (dmi.dmi_op == DMI_OP_WRITE);
  assign is_rd   = dmi.dmi_valid && (dmi.dmi_op == DMI_OP_READ);
  assign abs_clr = !dmactive_d;

  always_comb begin
    dmactive_d   = dmactive_q;
    haltreq_d    = haltreq_q;
    ndmreset_d   = ndmreset_q;
    resume_req_d = resume_req_q;
    resumeack_d  = resumeack_q;

    if (resume_req_q && hart_resumeack) begin
      resume_req_d = 1'b0;
      resumeack_d  = 1'b1;
    end

    // haltreq takes priority: a combined halt+resume write never starts a resume.
    if (is_wr && (dmi.dmi_addr == AddrWidth'(DMI_ADDR_DMCONTROL))) begin
      dmactive_d = wdata[DMCONTROL_DMACTIVE];
      haltreq_d  = wdata[DMCONTROL_HALTREQ];
      ndmreset_d = wdata[DMCONTROL_NDMRESET];
      if (wdata[DMCONTROL_RESUMEREQ] && !wdata[DMCONTROL_HALTREQ] && hart_halted) begin
        resume_req_d = 1'b1;
        resumeack_d  = 1'b0;
      end
    end

    if (!dmactive_d) begin
      haltreq_d    = 1'b0;
      ndmreset_d   = 1'b0;
      resume_req_d = 1'b0;
      resumeack_d  = 1'b0;
    end
  end

  always_comb begin
    dmcontrol_rd                     = '0;
    dmcontrol_rd[DMCONTROL_HALTREQ]  = haltreq_q;
    dmcontrol_rd[DMCONTROL_NDMRESET] = ndmreset_q;
    dmcontrol_rd[DMCONTROL_DMACTIVE] = dmactive_q;

    dmstatus_rd                                 = '0;
    dmstatus_rd[DMSTATUS_ALLRESUMEACK]          = resumeack_q;
    dmstatus_rd[DMSTATUS_ANYRESUMEACK]          = resumeack_q;
    dmstatus_rd[DMSTATUS_ALLRUNNING]            = !hart_halted;
    dmstatus_rd[DMSTATUS_ANYRUNNING]            = !hart_halted;
    dmstatus_rd[DMSTATUS_ALLHALTED]             = hart_halted;
    dmstatus_rd[DMSTATUS_ANYHALTED]             = hart_halted;
    dmstatus_rd[DMSTATUS_AUTHENTICATED]         = 1'b1;
    dmstatus_rd[DMSTATUS_VERSION_LSB +: 4]      = DM_VERSION;

    abstractcs_rd                               = '0;
    abstractcs_rd[ABSTRACTCS_BUSY]              = busy;
    abstractcs_rd[ABSTRACTCS_CMDERR_LSB +: 3]   = cmderr;
    abstractcs_rd[ABSTRACTCS_DATACOUNT_LSB +: 4] = DM_DATACOUNT;

    rsp_valid_d = dmi.dmi_valid;
    rsp_data_d  = '0;
    rsp_op_d    = DMI_RSP_OK;
    if (dmi.dmi_valid && (dmi.dmi_op == DMI_OP_RSVD)) begin
      rsp_op_d = DMI_RSP_FAILED;
    end else if (is_rd) begin
      case (dmi.dmi_addr)
        AddrWidth'(DMI_ADDR_DATA0):      rsp_data_d = data0;
        AddrWidth'(DMI_ADDR_DMCONTROL):  rsp_data_d = dmcontrol_rd;
        AddrWidth'(DMI_ADDR_DMSTATUS):   rsp_data_d = dmstatus_rd;
        AddrWidth'(DMI_ADDR_ABSTRACTCS): rsp_data_d = abstractcs_rd;
        default:                         rsp_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmactive_q   <= 1'b0;
      haltreq_q    <= 1'b0;
      ndmreset_q   <= 1'b0;
      resume_req_q <= 1'b0;
      resumeack_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_op_q     <= DMI_RSP_OK;
    end else begin
      dmactive_q   <= dmactive_d;
      haltreq_q    <= haltreq_d;
      ndmreset_q   <= ndmreset_d;
      resume_req_q <= resume_req_d;
      resumeack_q  <= resumeack_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_op_q     <= rsp_op_d;
    end
  end

  dm_abstract_cmd #(
    .Xlen       (Xlen),
    .CmdTimeout (CmdTimeout)
  ) u_abstract_cmd (
    .clk           (clk),
    .rst_n         (rst_n),
    .clr           (abs_clr),
    .data0_wr      (is_wr && dmactive_q && (dmi.dmi_addr == AddrWidth'(DMI_ADDR_DATA0))),
    .data0_rd      (is_rd && dmactive_q && (dmi.dmi_addr == AddrWidth'(DMI_ADDR_DATA0))),
    .abstractcs_wr (is_wr && dmactive_q && (dmi.dmi_addr == AddrWidth'(DMI_ADDR_ABSTRACTCS))),
    .command_wr    (is_wr && dmactive_q && (dmi.dmi_addr == AddrWidth'(DMI_ADDR_COMMAND))),
    .wdata         (wdata),
    .hart_halted   (hart_halted),
    .data0         (data0),
    .busy          (busy),
    .cmderr        (cmderr),
    .reg_req       (reg_req),
    .reg_write     (reg_write),
    .reg_addr      (reg_addr),
    .reg_wdata     (reg_wdata),
    .reg_rdata     (reg_rdata),
    .reg_ack       (reg_ack),
    .reg_err       (reg_err)
  );

  assign ndmreset          = ndmreset_q;
  assign halt_req          = haltreq_q;
  assign resume_req        = resume_req_q;
  assign dmi.dmi_rsp_valid = rsp_valid_q;
  assign dmi.dmi_rsp_data  = rsp_data_q;
  assign dmi.dmi_rsp_op    = rsp_op_q;

endmodule
`default_nettype wire

// File: tb/tb_dm_run_ctl.sv
`default_nettype none
// ============================================================================
// tb_dm_run_ctl : scoreboard bench for DMI responses and core handshake | rev 1.0
// ============================================================================
module tb_dm_run_ctl;
  import dm_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hart_halted = 1'b0;
  logic        hart_resumeack = 1'b0;
  logic [31:0] reg_rdata = 32'h0;
  logic        reg_ack = 1'b0;
  logic        reg_err = 1'b0;
  logic        ndmreset, halt_req, resume_req, reg_req, reg_write;
  logic [15:0] reg_addr;
  logic [31:0] reg_wdata;

  always #5 clk = ~clk;

  dm_run_ctl_if #(.AddrWidth(7), .Xlen(32)) dmi ();

  dm_run_ctl #(.AddrWidth(7), .Xlen(32), .CmdTimeout(255)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .dmi            (dmi),
    .ndmreset       (ndmreset),
    .halt_req       (halt_req),
    .resume_req     (resume_req),
    .hart_halted    (hart_halted),
    .hart_resumeack (hart_resumeack),
    .reg_req        (reg_req),
    .reg_write      (reg_write),
    .reg_addr       (reg_addr),
    .reg_wdata      (reg_wdata),
    .reg_rdata      (reg_rdata),
    .reg_ack        (reg_ack),
    .reg_err        (reg_err)
  );

  typedef struct {
    string       name;
    logic [31:0] data;
    logic [1:0]  op;
  } rsp_t;

  rsp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Response monitor: every DMI response is matched against the oldest expectation.
  always @(negedge clk) begin
    rsp_t e;
    if (rst_n && dmi.dmi_rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp: got data 0x%08h with no request outstanding", dmi.dmi_rsp_data);
      end else begin
        e = exp_q.pop_front();
        check({e.name, "_data"}, dmi.dmi_rsp_data, e.data);
        check({e.name, "_op"}, {30'd0, dmi.dmi_rsp_op}, {30'd0, e.op});
      end
    end
  end

  task automatic dmi_xfer(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data,
                          input logic [31:0] exp_data, input logic [1:0] exp_op, input string name);
    rsp_t e;
    @(posedge clk); #1;
    dmi.dmi_valid = 1'b1;
    dmi.dmi_op    = op;
    dmi.dmi_addr  = addr;
    dmi.dmi_data  = data;
    e.name = name;
    e.data = exp_data;
    e.op   = exp_op;
    exp_q.push_back(e);
    @(posedge clk); #1;
    dmi.dmi_valid = 1'b0;
    dmi.dmi_op    = 2'd0;
    dmi.dmi_addr  = 7'd0;
    dmi.dmi_data  = 32'd0;
  endtask

  task automatic wr(input logic [6:0] addr, input logic [31:0] data, input string name);
    dmi_xfer(2'd2, addr, data, 32'd0, 2'd0, name);
  endtask

  task automatic rd(input logic [6:0] addr, input logic [31:0] exp, input string name);
    dmi_xfer(2'd1, addr, 32'd0, exp, 2'd0, name);
  endtask

  task automatic pulse_ack(input logic err);
    @(posedge clk); #1;
    reg_ack = 1'b1;
    reg_err = err;
    @(posedge clk); #1;
    reg_ack = 1'b0;
    reg_err = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    dmi.dmi_valid = 1'b0;
    dmi.dmi_op    = 2'd0;
    dmi.dmi_addr  = 7'd0;
    dmi.dmi_data  = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {27'd0, halt_req, resume_req, ndmreset, reg_req, dmi.dmi_rsp_valid}, 32'd0);
    rst_n = 1'b1;

    // Halt request, hart reports halted three cycles later
    wr(DMI_ADDR_DMCONTROL, 32'h8000_0001, "wr_halt");
    check("halt_req_set", {31'd0, halt_req}, 32'd1);
    repeat (3) @(posedge clk);
    #1 hart_halted = 1'b1;
    rd(DMI_ADDR_DMSTATUS, 32'h0000_0382, "dmstatus_halted");

    // Resume: ack pulse two cycles after the request; resume_req lasts three cycles
    wr(DMI_ADDR_DMCONTROL, 32'h4000_0001, "wr_resume");
    n = 0;
    fork
      begin
        repeat (2) @(posedge clk);
        #1 hart_resumeack = 1'b1;
        @(posedge clk);
        #1 hart_resumeack = 1'b0;
        hart_halted = 1'b0;
      end
      begin
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          if (resume_req) n++;
        end
      end
    join
    check("resume_req_cycles", n, 32'd3);
    check("halt_req_cleared", {31'd0, halt_req}, 32'd0);
    rd(DMI_ADDR_DMSTATUS, 32'h0003_0C82, "dmstatus_resumed");
    wr(DMI_ADDR_DMCONTROL, 32'h4000_0001, "wr_resume_running");
    check("resume_ignored_running", {31'd0, resume_req}, 32'd0);
    rd(DMI_ADDR_DMSTATUS, 32'h0003_0C82, "dmstatus_still_acked");

    // Abstract register read completing after four cycles
    hart_halted = 1'b1;
    wr(DMI_ADDR_COMMAND, 32'h0022_1005, "wr_cmd_read");
    check("cmd_read_req", {reg_req, reg_write, 14'd0, reg_addr}, {1'b1, 1'b0, 14'd0, 16'h1005});
    rd(DMI_ADDR_ABSTRACTCS, 32'h0000_1001, "abstractcs_busy");
    reg_rdata = 32'hDEAD_BEEF;
    pulse_ack(1'b0);
    check("cmd_read_req_dropped", {31'd0, reg_req}, 32'd0);
    rd(DMI_ADDR_DATA0, 32'hDEAD_BEEF, "data0_loaded");
    rd(DMI_ADDR_ABSTRACTCS, 32'h0000_0001, "abstractcs_done");

    // Hart running and unsupported size
    hart_halted = 1'b0;
    wr(DMI_ADDR_COMMAND, 32'h0023_1001, "wr_cmd_running");
    check("no_req_running", {31'd0, reg_req}, 32'd0);
    rd(DMI_ADDR_ABSTRACTCS, 32'h0000_0401, "cmderr_haltresume");
    wr(DMI_ADDR_ABSTRACTCS, 32'h0000_0700, "clr_cmderr_a");
    rd(DMI_ADDR_ABSTRACTCS, 32'h0000_0001, "cmderr_cleared");
    hart_halted = 1'b1;
    wr(DMI_ADDR_COMMAND, 32'h0032_1001, "wr_cmd_badsize");
    check("no_req_badsize", {31'd0, reg_req}, 32'd0);
    rd(DMI_ADDR_ABSTRACTCS, 32'h0000_0201, "cmderr_notsup");
    wr(DMI_ADDR_ABSTRACTCS, 32'h0000_0700, "clr_cmderr_b");

    // Timeout: no reg_ack at all
    wr(DMI_ADDR_COMMAND, 32'h0022_1001, "wr_cmd_timeout");
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!reg_req) break;
      n++;
    end
    check("timeout_window", {31'd0, (n >= 255) && (n <= 258)}, 32'd1);
    rd(DMI_ADDR_ABSTRACTCS, 32'h0000_0301, "cmderr_except");
    wr(DMI_ADDR_ABSTRACTCS, 32'h0000_0700, "clr_cmderr_c");

    // Register write command, with data0 and command accesses while busy
    wr(DMI_ADDR_DATA0, 32'hA5A5_0001, "wr_data0");
    wr(DMI_ADDR_COMMAND, 32'h0023_1002, "wr_cmd_write");
    check("cmd_write_req", {reg_req, reg_write, 14'd0, reg_addr}, {1'b1, 1'b1, 14'd0, 16'h1002});
    check("cmd_write_wdata", reg_wdata, 32'hA5A5_0001);
    wr(DMI_ADDR_DATA0, 32'hFFFF_FFFF, "wr_data0_busy");
    rd(DMI_ADDR_DATA0, 32'hA5A5_0001, "data0_busy_old");
    wr(DMI_ADDR_COMMAND, 32'h0022_1004, "wr_cmd_busy");
    rd(DMI_ADDR_ABSTRACTCS, 32'h0000_1101, "cmderr_busy");
    check("cmd_busy_ignored", {16'd0, reg_addr}, 32'h0000_1002);
    pulse_ack(1'b0);
    rd(DMI_ADDR_DATA0, 32'hA5A5_0001, "data0_after_write");
    rd(DMI_ADDR_ABSTRACTCS, 32'h0000_0101, "cmderr_busy_kept");
    wr(DMI_ADDR_ABSTRACTCS, 32'h0000_0100, "clr_cmderr_d");

    // Error ack
    wr(DMI_ADDR_COMMAND, 32'h0022_1007, "wr_cmd_err");
    pulse_ack(1'b1);
    rd(DMI_ADDR_ABSTRACTCS, 32'h0000_0301, "cmderr_reg_err");
    wr(DMI_ADDR_ABSTRACTCS, 32'h0000_0700, "clr_cmderr_e");

    // Abort by clearing dmactive mid-command
    wr(DMI_ADDR_DATA0, 32'h1111_2222, "wr_data0_pre_abort");
    wr(DMI_ADDR_DMCONTROL, 32'h8000_0001, "wr_halt_again");
    wr(DMI_ADDR_COMMAND, 32'h0022_1003, "wr_cmd_abort");
    check("abort_req_before", {31'd0, reg_req}, 32'd1);
    wr(DMI_ADDR_DMCONTROL, 32'h0000_0000, "wr_deactivate");
    check("abort_outputs", {30'd0, reg_req, halt_req}, 32'd0);
    rd(DMI_ADDR_DATA0, 32'h0000_0000, "data0_aborted");
    rd(DMI_ADDR_ABSTRACTCS, 32'h0000_0001, "abstractcs_aborted");
    wr(DMI_ADDR_DATA0, 32'h9999_9999, "wr_data0_inactive");
    reg_rdata = 32'h7777_7777;
    pulse_ack(1'b0);
    wr(DMI_ADDR_DMCONTROL, 32'h0000_0001, "wr_reactivate");
    rd(DMI_ADDR_DATA0, 32'h0000_0000, "data0_late_ack");

    // Misc ops, unmapped addresses, combined halt+resume
    dmi_xfer(2'd0, DMI_ADDR_DMCONTROL, 32'h0, 32'h0, DMI_RSP_OK, "nop");
    dmi_xfer(2'd3, DMI_ADDR_DATA0, 32'h0, 32'h0, DMI_RSP_FAILED, "reserved_op");
    wr(7'h21, 32'h1234_5678, "wr_unmapped");
    rd(7'h20, 32'h0000_0000, "rd_unmapped");
    wr(DMI_ADDR_DMCONTROL, 32'hC000_0003, "wr_halt_resume");
    check("halt_wins", {29'd0, halt_req, resume_req, ndmreset}, 32'h5);
    rd(DMI_ADDR_DMCONTROL, 32'h8000_0003, "dmcontrol_readback");
    wr(DMI_ADDR_COMMAND, 32'h0022_1006, "wr_cmd_pre_reset");
    check("req_before_reset", {31'd0, reg_req}, 32'd1);

    // Asynchronous reset mid-cycle
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {28'd0, halt_req, resume_req, ndmreset, reg_req}, 32'd0);
    check("rsp_queue_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
